// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: ALU opcodes, slice
// function selects and controller FSM states.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;

  localparam logic [1:0] FN_AND = 2'd0;
  localparam logic [1:0] FN_OR  = 2'd1;
  localparam logic [1:0] FN_SUM = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_NOR);
  endfunction

  function automatic logic op_is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational 1-bit ALU slice with optional operand inversion and a
// majority-function ripple carry.
module alu_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       ainv,
  input  logic       binv,
  input  logic       carry_in,
  input  logic [1:0] fn,
  output logic       res,
  output logic       carry_out
);

  logic a_eff;
  logic b_eff;

  assign a_eff     = a ^ ainv;
  assign b_eff     = b ^ binv;
  assign carry_out = (a_eff & b_eff) | (a_eff & carry_in) | (b_eff & carry_in);

  always_comb begin
    res = 1'b0;
    case (fn)
      FN_AND:  res = a_eff & b_eff;
      FN_OR:   res = a_eff | b_eff;
      FN_SUM:  res = a_eff ^ b_eff ^ carry_in;
      default: res = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: accepts an operation, runs it LSB-first through a
// single alu_slice with a registered ripple carry, then presents result+flags.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             op_error,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; ready never depends combinationally on valid, and this block
  // holds result_valid and all result/flag outputs stable until accepted.

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic       sl_ainv;
  logic       sl_binv;
  logic [1:0] sl_fn;
  logic       sl_res;
  logic       sl_cout;
  logic       arith;

  assign arith   = op_is_arith(op_q);
  assign sl_ainv = (op_q == OP_NOR);
  assign sl_binv = (op_q == OP_SUB) || (op_q == OP_NOR);
  assign sl_fn   = arith ? FN_SUM : ((op_q == OP_OR) ? FN_OR : FN_AND);

  alu_slice u_slice (
    .a         (a_q[idx_q]),
    .b         (b_q[idx_q]),
    .ainv      (sl_ainv),
    .binv      (sl_binv),
    .carry_in  (carry_q),
    .fn        (sl_fn),
    .res       (sl_res),
    .carry_out (sl_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    work_d  = work_q;
    res_d   = res_q;
    zero_d  = zero_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          a_d    = a_in;
          b_d    = b_in;
          op_d   = op;
          idx_d  = '0;
          work_d = '0;
          if (op_is_legal(op)) begin
            state_d = S_RUN;
            carry_d = (op == OP_SUB);
          end else begin
            state_d = S_DONE;
            carry_d = 1'b0;
            res_d   = '0;
            zero_d  = 1'b1;
            cout_d  = 1'b0;
            ovf_d   = 1'b0;
            err_d   = 1'b1;
          end
        end
      end
      S_RUN: begin
        work_d[idx_q] = sl_res;
        carry_d       = arith ? sl_cout : 1'b0;
        idx_d         = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // carry_q is the carry into the MSB; sl_cout is the carry out of it
          state_d = S_DONE;
          idx_d   = '0;
          res_d   = work_d;
          zero_d  = ~|work_d;
          cout_d  = arith ? sl_cout : 1'b0;
          ovf_d   = arith ? (carry_q ^ sl_cout) : 1'b0;
          err_d   = 1'b0;
        end
      end
      S_DONE: begin
        if (result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      work_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      work_q  <= work_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign start_ready  = (state_q == S_IDLE);
  assign result_valid = (state_q == S_DONE);
  assign result       = res_q;
  assign zero         = zero_q;
  assign carry_out    = cout_q;
  assign overflow     = ovf_q;
  assign op_error     = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed self-checking bench for alu_serial_ctrl (WIDTH=8) with a
// scoreboard of expected {op_error, overflow, carry_out, zero, result}.
module tb_alu_serial_ctrl;

  localparam int W  = 8;
  localparam int EW = W + 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [3:0]   op_i = '0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         result_valid;
  logic         result_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic         carry_out;
  logic         overflow;
  logic         op_error;
  logic [1:0]   dbg_state;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .op           (op_i),
    .a_in         (a_i),
    .b_in         (b_i),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .zero         (zero),
    .carry_out    (carry_out),
    .overflow     (overflow),
    .op_error     (op_error),
    .dbg_state    (dbg_state)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  function automatic logic [EW-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         e;
    r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b0010: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[W-1:0];
        c = s[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'b0110: begin
        s = {1'b0, a} + {1'b0, ~b} + 1;
        r = s[W-1:0];
        c = s[W];
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      default: e = 1'b1;
    endcase
    return {e, v, c, (r == '0), r};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic compare_out(input string tag, input logic [EW-1:0] e);
    check(tag, 64'({op_error, overflow, carry_out, zero, result}), 64'(e));
  endtask

  // driver: present op at negedge, return just after the accepting edge
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    start_valid = 1'b1;
    op_i = op;
    a_i  = a;
    b_i  = b;
    for (int i = 0; i < 40; i++) begin
      if (start_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 start_valid = 1'b0;
    if (!ok) check("accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int cnt;
    bit got;
    cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (result_valid) begin
        got = 1'b1;
        break;
      end
    end
    check(tag, got ? 64'(cnt) : 64'hFFFF, 64'(exp_lat));
  endtask

  task automatic pop_check(input string tag, output logic [EW-1:0] e);
    if (exp_q.size() == 0) begin
      e = '0;
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      compare_out(tag, e);
    end
  endtask

  task automatic release_result(input string tag);
    result_ready = 1'b1;
    @(posedge clk);
    #1 result_ready = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, 64'({start_ready, result_valid}), 64'b10);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_lat);
    logic [EW-1:0] e;
    exp_q.push_back(model(op, a, b));
    issue(op, a, b);
    wait_valid({tag, "_lat"}, exp_lat);
    pop_check(tag, e);
    release_result(tag);
  endtask

  initial begin : stim
    logic [EW-1:0] e;

    // reset state
    #1;
    check("rst_outputs", 64'({result, zero, carry_out, overflow, op_error, result_valid}), 64'd0);
    check("rst_start_ready", 64'(start_ready), 64'd1);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // arithmetic
    run_op("add_7f_01", 4'b0010, 8'h7F, 8'h01, 8);
    run_op("sub_05_05", 4'b0110, 8'h05, 8'h05, 8);
    run_op("sub_03_05", 4'b0110, 8'h03, 8'h05, 8);
    run_op("sub_80_01", 4'b0110, 8'h80, 8'h01, 8);

    // logical
    run_op("and_f0_3c", 4'b0000, 8'hF0, 8'h3C, 8);
    run_op("or_f0_3c",  4'b0001, 8'hF0, 8'h3C, 8);
    run_op("nor_f0_3c", 4'b1100, 8'hF0, 8'h3C, 8);

    // illegal op then legal op clears op_error
    run_op("illegal_0111", 4'b0111, 8'hAA, 8'h55, 1);
    run_op("add_after_illegal", 4'b0010, 8'h10, 8'h20, 8);

    // a few random ops
    for (int i = 0; i < 4; i++) begin
      logic [3:0] rop;
      case ($urandom_range(0, 4))
        0: rop = 4'b0000;
        1: rop = 4'b0001;
        2: rop = 4'b0010;
        3: rop = 4'b0110;
        default: rop = 4'b1100;
      endcase
      run_op("rand_op", rop, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8);
    end

    // backpressure with a waiting requester
    exp_q.push_back(model(4'b0010, 8'h12, 8'h34));
    issue(4'b0010, 8'h12, 8'h34);
    wait_valid("bp_lat", 8);
    pop_check("bp_first", e);
    for (int i = 0; i < 5; i++) begin
      start_valid = (i % 2 == 0);
      op_i = 4'b0001;
      a_i  = 8'hA5;
      b_i  = 8'h0F;
      @(posedge clk);
      @(negedge clk);
      compare_out("bp_hold", e);
      check("bp_start_ready", 64'({start_ready, result_valid}), 64'b01);
    end
    exp_q.push_back(model(4'b0001, 8'hA5, 8'h0F));
    start_valid  = 1'b1;
    result_ready = 1'b1;
    @(posedge clk);
    #1 result_ready = 1'b0;
    @(negedge clk);
    check("bp_release_idle", 64'({start_ready, result_valid}), 64'b10);
    @(posedge clk);
    #1 start_valid = 1'b0;
    wait_valid("bp_queued_lat", 8);
    pop_check("bp_queued", e);
    release_result("bp_queued");

    // asynchronous reset mid-RUN, at bit 3 of an ADD
    issue(4'b0010, 8'h55, 8'h22);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outputs", 64'({result, zero, carry_out, overflow, op_error, result_valid}), 64'd0);
    check("abort_start_ready", 64'(start_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort_no_valid", 64'(result_valid), 64'd0);
    end
    run_op("add_ff_01", 4'b0010, 8'hFF, 8'h01, 8);

    check("sb_drained", 64'(exp_q.size()), 64'd0);

    // report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
